// File: rtl/ws2812_refresh_scheduler.sv
// ws2812_refresh_scheduler: shares one WS2812 transmit engine among NUM_REQ generators on a ms refresh period.
// Define WS_SCHED_WDOG_EN to add a tick_1ms watchdog that aborts frames the engine never finishes.
module ws2812_refresh_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int REFRESH_MS = 20,
  parameter int GAP_CYCLES = 15000,
  parameter int TIMEOUT_MS = 10,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               tick_1ms,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic               tx_done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               tx_start,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic               tx_abort,
  output logic               timeout_err
);
  localparam int RW = (REFRESH_MS > 1) ? $clog2(REFRESH_MS) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, ARB, START, BUSY, GAP} state_t;
  state_t             state_q, state_d;
  logic [RW-1:0]      ref_cnt_q, ref_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick_oh;
  logic [IW-1:0]      idx_q, idx_d, last_q, last_d, pick;
  logic               frame_due_q, frame_due_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;
  logic               wrap, due_clr, wd_fire;
  // Round-robin: lowest set bit above last wins, otherwise lowest set bit overall.
  always_comb begin
    pick = last_q;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) pick = IW'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i] && i > int'(last_q)) pick = IW'(i);
    pick_oh = '0;
    for (int i = 0; i < NUM_REQ; i++)
      pick_oh[i] = (IW'(i) == pick);
  end
  // A period set in the same cycle as a clear wins, so no refresh is lost.
  always_comb begin
    wrap        = enable && tick_1ms && (ref_cnt_q == RW'(REFRESH_MS - 1));
    ref_cnt_d   = !enable ? '0 : !tick_1ms ? ref_cnt_q : wrap ? '0 : ref_cnt_q + 1'b1;
    due_clr     = (state_q == ARB) || (state_q == IDLE && enable && frame_due_q && !(|req));
    frame_due_d = !enable ? 1'b0 : wrap ? 1'b1 : due_clr ? 1'b0 : frame_due_q;
    overrun_d   = wrap && frame_due_q;
  end
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    idx_d        = idx_q;
    last_d       = last_q;
    gap_cnt_d    = gap_cnt_q;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE:
        if (enable && frame_due_q && |req) state_d = ARB;
      ARB:
        if (|req) begin
          state_d    = START;
          grant_d    = pick_oh;
          idx_d      = pick;
          last_d     = pick;
          tx_start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      START:
        state_d = BUSY;
      BUSY:
        if (tx_done || wd_fire) begin
          state_d      = GAP;
          grant_d      = '0;
          idx_d        = '0;
          gap_cnt_d    = '0;
          frame_done_d = 1'b1;
        end
      GAP:
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      default:
        state_d = IDLE;
    endcase
    busy_d = state_d inside {START, BUSY, GAP};
  end
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ref_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      grant_q      <= '0;
      idx_q        <= '0;
      last_q       <= IW'(NUM_REQ - 1);
      frame_due_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_cnt_q    <= ref_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      grant_q      <= grant_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      frame_due_q  <= frame_due_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end
`ifdef WS_SCHED_WDOG_EN
  localparam int TW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          tx_abort_q, timeout_err_q, timeout_err_d;
  // A tx_done arriving with the final tick completes the frame normally.
  always_comb begin
    wd_fire       = (state_q == BUSY) && tick_1ms && !tx_done && (wd_cnt_q == TW'(TIMEOUT_MS - 1));
    wd_cnt_d      = (state_q != BUSY) ? '0 : (tick_1ms && !wd_fire) ? wd_cnt_q + 1'b1 : wd_cnt_q;
    timeout_err_d = timeout_err_q || wd_fire;
  end
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      tx_abort_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      tx_abort_q    <= wd_fire;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign tx_abort    = tx_abort_q;
  assign timeout_err = timeout_err_q;
`else
  assign wd_fire     = 1'b0;
  assign tx_abort    = 1'b0;
  assign timeout_err = 1'b0;
`endif
  assign grant      = grant_q;
  assign grant_idx  = idx_q;
  assign tx_start   = tx_start_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_ws2812_refresh_scheduler.sv
// tb_ws2812_refresh_scheduler: directed stimulus with a grant scoreboard checked on every tx_start.
module tb_ws2812_refresh_scheduler;
  localparam int NR = 4, RMS = 2, GAP = 8, TMS = 3;
  logic clkin = 1'b0, rst = 1'b1, tick_1ms = 1'b0, enable = 1'b0, tx_done = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] grant;
  logic [1:0]    grant_idx;
  logic          tx_start, busy, frame_done, overrun, tx_abort, timeout_err;
  int checks = 0, errors = 0, n_start = 0, n_fd = 0, n_ovr = 0, n_abort = 0, e;
  int sb[$];

  always #5 clkin = ~clkin;

  ws2812_refresh_scheduler #(.NUM_REQ(NR), .REFRESH_MS(RMS), .GAP_CYCLES(GAP), .TIMEOUT_MS(TMS)) dut (
    .clkin(clkin), .rst(rst), .tick_1ms(tick_1ms), .enable(enable), .req(req), .tx_done(tx_done),
    .grant(grant), .grant_idx(grant_idx), .tx_start(tx_start), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .tx_abort(tx_abort), .timeout_err(timeout_err)
  );

  always @(negedge clkin) begin
    if (overrun) n_ovr++;
    if (frame_done) n_fd++;
    if (tx_abort) n_abort++;
    if (tx_start) begin
      n_start++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: grant_idx=%0d grant=%b but no frame expected", grant_idx, grant);
      end else begin
        e = sb.pop_front();
        if (grant_idx !== 2'(e) || grant !== NR'(1 << e)) begin
          errors++;
          $display("FAIL grant_on_start: got idx=%0d grant=%b, expected idx=%0d grant=%b", grant_idx, grant, e, NR'(1 << e));
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic tick();
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
  endtask

  task automatic period();
    tick();
    tick();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (!tx_start && lat < 30) begin
      step();
      lat++;
    end
    chk("tx_start_seen", tx_start, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("returns_idle", busy, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_grant", grant, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_tx_abort", tx_abort, 0);
    chk("rst_timeout_err", timeout_err, 0);
  endtask

  task automatic frame(int idx, int dly);
    int lat, fd0;
    sb.push_back(idx);
    fd0 = n_fd;
    period();
    wait_start(lat);
    chk("start_latency", lat, 2);
    step(dly);
    chk("busy_held", busy, 1);
    chk("grant_held", grant, 1 << idx);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    wait_idle();
    chk("one_frame_done", n_fd - fd0, 1);
  endtask

  initial begin
    int lat, k, st0, fd0, ovr0;
    step(2);
    chk_reset_outputs();
    rst = 1'b0;
    enable = 1'b1;
    step(2);
    // single requester
    req = 4'b0001;
    frame(0, 5);
    frame(0, 5);
    // round-robin over all requesters
    req = 4'b1111;
    frame(1, 3);
    frame(2, 3);
    frame(3, 3);
    frame(0, 3);
    // empty request skips the period without overrun
    req = 4'b0000;
    st0 = n_start;
    ovr0 = n_ovr;
    period();
    step(5);
    chk("skip_no_start", n_start - st0, 0);
    req = 4'b0100;
    frame(2, 4);
    chk("skip_no_overrun", n_ovr - ovr0, 0);
    // engine stalls across three periods
    req = 4'b0001;
    sb.push_back(0);
    period();
    wait_start(lat);
    ovr0 = n_ovr;
    period();
    period();
    period();
    step();
    chk("overrun_count", n_ovr - ovr0, 2);
    sb.push_back(0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("frame_done_first_gap", frame_done, 1);
    k = 1;
    while (!tx_start && k < 60) begin
      step();
      k++;
    end
    chk("gap_to_next_start", k, GAP + 3);
    step(4);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    wait_idle();
    st0 = n_start;
    step(20);
    chk("single_queued_frame", n_start - st0, 0);
    // tx_done while idle is ignored
    fd0 = n_fd;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step(3);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_no_frame", n_fd - fd0, 0);
    chk("idle_done_no_start", n_start - st0, 0);
    // reset mid-frame
    req = 4'b1111;
    sb.push_back(1);
    period();
    wait_start(lat);
    step(2);
    chk("busy_grant_before_rst", grant, 4'b0010);
    rst = 1'b1;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_busy", busy, 0);
    step(2);
    rst = 1'b0;
    chk_reset_outputs();
    frame(0, 3);
    frame(1, 3);
`ifdef WS_SCHED_WDOG_EN
    req = 4'b0100;
    sb.push_back(2);
    period();
    wait_start(lat);
    step();
    tick();
    tick();
    chk("wd_no_early_abort", tx_abort, 0);
    tick();
    chk("wd_abort", tx_abort, 1);
    chk("wd_err_set", timeout_err, 1);
    chk("wd_frame_done", frame_done, 1);
    step(3);
    chk("wd_err_sticky", timeout_err, 1);
    chk("wd_abort_pulse", n_abort, 1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("wd_err_cleared", timeout_err, 0);
`else
    chk("no_abort", n_abort, 0);
    chk("no_timeout_err", timeout_err, 0);
`endif
    step(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, %0d errors so far", errors);
    $fatal(1);
  end
endmodule
